// File: rtl/avr_mem_pkg.sv
// Shared definitions for the AVR data-memory arbiter: memory map defaults,
// the mapped-address test and the arbiter FSM state encoding.
package avr_mem_pkg;

  localparam logic [15:0] LO_TOP_DEF  = 16'h17FF;
  localparam logic [15:0] HI_BASE_DEF = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  // True when the address falls into one of the two populated windows.
  function automatic logic is_mapped(input logic [15:0] addr,
                                     input logic [15:0] lo_top,
                                     input logic [15:0] hi_base);
    return (addr <= lo_top) || (addr >= hi_base);
  endfunction

endpackage

// File: rtl/dma_burst_ctr.sv
// Address and remaining-length counters for one DMA burst.
// The address wraps naturally from $FFFF to $0000.
module dma_burst_ctr #(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clock,
  input  logic             locked,
  input  logic             load,
  input  logic [15:0]      load_addr,
  input  logic [LEN_W-1:0] load_len,
  input  logic             step,
  output logic [15:0]      addr,
  output logic             last
);

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [LEN_W-1:0] remain;

  // Load a new burst, or advance one byte per granted DMA slot.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      addr   <= 16'h0000;
      remain <= '0;
    end else if (load) begin
      addr   <= load_addr;
      remain <= load_len;
    end else if (step) begin
      addr   <= addr + 16'h0001;
      remain <= remain - ONE;
    end
  end

  assign last = (remain == ONE);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the AVR core (priority) and a
// burst-read DMA engine, with a starvation counter that forces DMA slots and
// a memory-map filter that blocks writes and returns $FF in the unmapped hole.
module dmem_arbiter
  import avr_mem_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned LEN_W      = 16,
  parameter logic [15:0] LO_TOP     = LO_TOP_DEF,
  parameter logic [15:0] HI_BASE    = HI_BASE_DEF
) (
  input  logic             clock,
  input  logic             locked,
  input  logic [15:0]      cpu_address,
  input  logic             cpu_rd,
  input  logic             cpu_w,
  input  logic [7:0]       cpu_wb,
  output logic [7:0]       cpu_data,
  output logic             cpu_wait,
  input  logic             dma_start,
  input  logic [15:0]      dma_addr,
  input  logic [LEN_W-1:0] dma_len,
  output logic             dma_busy,
  output logic [7:0]       dma_rdata,
  output logic             dma_rvalid,
  output logic             dma_done,
  output logic [15:0]      mem_address,
  output logic [7:0]       mem_wdata,
  output logic             mem_w,
  input  logic [7:0]       mem_rdata
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t state, state_next;
  logic [3:0]  starve_cnt;
  logic        cpu_req, in_burst, dma_grant, cpu_grant, cpu_read;
  logic        load, last_byte;
  logic [15:0] dma_cur;
  logic        rd_pend, rd_owner, rd_unmapped;
  logic [7:0]  cpu_hold, ret_data;

  assign cpu_req   = cpu_rd | cpu_w;
  assign in_burst  = (state == BURST);
  assign dma_grant = in_burst && ((starve_cnt == STARVE_LIM) || !cpu_req);
  assign cpu_grant = locked && cpu_req && !dma_grant;
  assign cpu_read  = cpu_grant && cpu_rd && !cpu_w;
  assign cpu_wait  = dma_grant && cpu_req;
  assign load      = (state == IDLE) && dma_start && (dma_len != '0);

  dma_burst_ctr #(.LEN_W(LEN_W)) u_ctr (
    .clock     (clock),
    .locked    (locked),
    .load      (load),
    .load_addr (dma_addr),
    .load_len  (dma_len),
    .step      (dma_grant),
    .addr      (dma_cur),
    .last      (last_byte)
  );

  // Drive the RAM port from whichever requester owns this slot.
  always_comb begin
    mem_address = 16'h0000;
    mem_wdata   = 8'h00;
    mem_w       = 1'b0;
    if (dma_grant) begin
      mem_address = dma_cur;
    end else if (cpu_grant) begin
      mem_address = cpu_address;
      if (cpu_w) begin
        mem_wdata = cpu_wb;
        mem_w     = is_mapped(cpu_address, LO_TOP, HI_BASE);
      end
    end
  end

  // State register.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; a new burst is only accepted from IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (dma_start) state_next = (dma_len != '0) ? BURST : DONE;
      BURST:   if (dma_grant && last_byte) state_next = DRAIN;
      DRAIN:   state_next = IDLE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Count consecutive denied DMA cycles; any DMA grant or leaving BURST clears it.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked)                    starve_cnt <= 4'd0;
    else if (!in_burst || dma_grant) starve_cnt <= 4'd0;
    else                            starve_cnt <= starve_cnt + 4'd1;
  end

  // Tag each read slot with its owner so the returning byte can be routed.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked) begin
      rd_pend     <= 1'b0;
      rd_owner    <= 1'b0;
      rd_unmapped <= 1'b0;
    end else begin
      rd_pend     <= dma_grant || cpu_read;
      rd_owner    <= dma_grant;
      rd_unmapped <= !is_mapped(mem_address, LO_TOP, HI_BASE);
    end
  end

  assign ret_data = rd_unmapped ? 8'hFF : mem_rdata;

  // Remember the last byte returned to the CPU so cpu_data holds between reads.
  always_ff @(posedge clock or negedge locked) begin
    if (!locked)                   cpu_hold <= 8'h00;
    else if (rd_pend && !rd_owner) cpu_hold <= ret_data;
  end

  assign cpu_data   = (rd_pend && !rd_owner) ? ret_data : cpu_hold;
  assign dma_rvalid = rd_pend && rd_owner;
  assign dma_rdata  = dma_rvalid ? ret_data : 8'h00;
  assign dma_busy   = (state == BURST) || (state == DRAIN);
  assign dma_done   = (state == DRAIN) || (state == DONE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
module tb_dmem_arbiter;

  logic        clock = 1'b0;
  logic        locked;
  logic [15:0] cpu_address;
  logic        cpu_rd, cpu_w;
  logic [7:0]  cpu_wb;
  logic [7:0]  cpu_data;
  logic        cpu_wait;
  logic        dma_start;
  logic [15:0] dma_addr;
  logic [15:0] dma_len;
  logic        dma_busy;
  logic [7:0]  dma_rdata;
  logic        dma_rvalid;
  logic        dma_done;
  logic [15:0] mem_address;
  logic [7:0]  mem_wdata;
  logic        mem_w;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:65535];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [15:0] c_addr;
    logic        c_rd;
    logic        c_w;
    logic [7:0]  c_wb;
    logic        d_start;
    logic [15:0] d_addr;
    logic [15:0] d_len;
    logic [15:0] e_maddr;
    logic        e_mw;
    logic        e_wait;
    logic [7:0]  e_cdata;
    logic        e_busy;
    logic        e_rvalid;
    logic [7:0]  e_rdata;
    logic        e_done;
  } vec_t;

  vec_t vecs [16];

  dmem_arbiter dut (
    .clock       (clock),
    .locked      (locked),
    .cpu_address (cpu_address),
    .cpu_rd      (cpu_rd),
    .cpu_w       (cpu_w),
    .cpu_wb      (cpu_wb),
    .cpu_data    (cpu_data),
    .cpu_wait    (cpu_wait),
    .dma_start   (dma_start),
    .dma_addr    (dma_addr),
    .dma_len     (dma_len),
    .dma_busy    (dma_busy),
    .dma_rdata   (dma_rdata),
    .dma_rvalid  (dma_rvalid),
    .dma_done    (dma_done),
    .mem_address (mem_address),
    .mem_wdata   (mem_wdata),
    .mem_w       (mem_w),
    .mem_rdata   (mem_rdata)
  );

  // Free-running clock, period 10.
  always #5 clock = ~clock;

  // Single-port RAM with one cycle of read latency.
  always @(posedge clock) begin
    if (mem_w) ram[mem_address] <= mem_wdata;
    mem_rdata <= ram[mem_address];
  end

  task automatic apply_stimulus(input logic [15:0] ca, input logic crd, input logic cw,
                                input logic [7:0] cwb, input logic ds,
                                input logic [15:0] da, input logic [15:0] dl);
    @(negedge clock);
    cpu_address = ca;
    cpu_rd      = crd;
    cpu_w       = cw;
    cpu_wb      = cwb;
    dma_start   = ds;
    dma_addr    = da;
    dma_len     = dl;
    #2;
  endtask

  task automatic idle_cycle();
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic check_output(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [15:0] e_addr;
    logic        e_wait, e_rv, e_done, e_busy;
    logic [7:0]  e_rd;

    for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
    ram[16'h8000] = 8'h01;
    ram[16'h8001] = 8'h02;
    ram[16'h8002] = 8'h03;
    ram[16'h8003] = 8'h04;
    ram[16'h4000] = 8'h33;
    ram[16'hFFFE] = 8'hA1;
    ram[16'hFFFF] = 8'hA2;
    ram[16'h0000] = 8'hA3;

    //        c_addr  rd    w     wb     start da        dl     | maddr    mw    wait  cdata  busy  rv    rdata  done
    vecs[0]  = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[1]  = '{16'h0100,1'b0,1'b1,8'h5A,1'b0,16'h0000,16'd0, 16'h0100,1'b1,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[2]  = '{16'h0100,1'b1,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0100,1'b0,1'b0,8'h00,1'b0,1'b0,8'h00,1'b0};
    vecs[3]  = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'h5A,1'b0,1'b0,8'h00,1'b0};
    vecs[4]  = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'h5A,1'b0,1'b0,8'h00,1'b0};
    vecs[5]  = '{16'h4000,1'b0,1'b1,8'h77,1'b0,16'h0000,16'd0, 16'h4000,1'b0,1'b0,8'h5A,1'b0,1'b0,8'h00,1'b0};
    vecs[6]  = '{16'h4000,1'b1,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h4000,1'b0,1'b0,8'h5A,1'b0,1'b0,8'h00,1'b0};
    vecs[7]  = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'hFF,1'b0,1'b0,8'h00,1'b0};
    vecs[8]  = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'hFF,1'b0,1'b0,8'h00,1'b0};
    vecs[9]  = '{16'h0000,1'b0,1'b0,8'h00,1'b1,16'h8000,16'd4, 16'h0000,1'b0,1'b0,8'hFF,1'b0,1'b0,8'h00,1'b0};
    vecs[10] = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h8000,1'b0,1'b0,8'hFF,1'b1,1'b0,8'h00,1'b0};
    vecs[11] = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h8001,1'b0,1'b0,8'hFF,1'b1,1'b1,8'h01,1'b0};
    vecs[12] = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h8002,1'b0,1'b0,8'hFF,1'b1,1'b1,8'h02,1'b0};
    vecs[13] = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h8003,1'b0,1'b0,8'hFF,1'b1,1'b1,8'h03,1'b0};
    vecs[14] = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'hFF,1'b1,1'b1,8'h04,1'b1};
    vecs[15] = '{16'h0000,1'b0,1'b0,8'h00,1'b0,16'h0000,16'd0, 16'h0000,1'b0,1'b0,8'hFF,1'b0,1'b0,8'h00,1'b0};

    locked      = 1'b0;
    cpu_address = 16'h0000;
    cpu_rd      = 1'b0;
    cpu_w       = 1'b0;
    cpu_wb      = 8'h00;
    dma_start   = 1'b0;
    dma_addr    = 16'h0000;
    dma_len     = 16'h0000;

    // Reset state.
    repeat (2) @(negedge clock);
    #2;
    check_output("reset_outputs",
                 {3'b0, mem_address, mem_w, cpu_wait, cpu_data, dma_busy, dma_rvalid, dma_rdata, dma_done},
                 40'h0);
    @(negedge clock);
    locked = 1'b1;

    // CPU write/read, unmapped access and a plain DMA burst with the CPU idle.
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i].c_addr, vecs[i].c_rd, vecs[i].c_w, vecs[i].c_wb,
                     vecs[i].d_start, vecs[i].d_addr, vecs[i].d_len);
      check_output($sformatf("vec%0d", i),
                   {3'b0, mem_address, mem_w, cpu_wait, cpu_data, dma_busy, dma_rvalid, dma_rdata, dma_done},
                   {3'b0, vecs[i].e_maddr, vecs[i].e_mw, vecs[i].e_wait, vecs[i].e_cdata,
                    vecs[i].e_busy, vecs[i].e_rvalid, vecs[i].e_rdata, vecs[i].e_done});
    end
    check_output("unmapped_ram_untouched", {32'h0, ram[16'h4000]}, {32'h0, 8'h33});

    // CPU reads every cycle while a 2-byte burst runs: DMA forced on k=5 and k=10.
    apply_stimulus(16'h0100, 1'b1, 1'b0, 8'h00, 1'b1, 16'h8000, 16'd2);
    for (int k = 1; k <= 12; k++) begin
      apply_stimulus(16'h0100, 1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 16'd0);
      e_wait = (k == 5) || (k == 10);
      e_addr = (k == 5) ? 16'h8000 : (k == 10) ? 16'h8001 : 16'h0100;
      e_rv   = (k == 6) || (k == 11);
      e_rd   = (k == 6) ? 8'h01 : (k == 11) ? 8'h02 : 8'h00;
      e_done = (k == 11);
      e_busy = (k <= 11);
      check_output($sformatf("starve_k%0d", k),
                   {12'h0, cpu_wait, mem_address, dma_rvalid, dma_rdata, dma_done, dma_busy},
                   {12'h0, e_wait, e_addr, e_rv, e_rd, e_done, e_busy});
    end

    // Burst across the top of the address space.
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'hFFFE, 16'd3);
    for (int k = 1; k <= 5; k++) begin
      idle_cycle();
      e_addr = (k == 1) ? 16'hFFFE : (k == 2) ? 16'hFFFF : 16'h0000;
      e_rv   = (k >= 2) && (k <= 4);
      e_rd   = (k == 2) ? 8'hA1 : (k == 3) ? 8'hA2 : (k == 4) ? 8'hA3 : 8'h00;
      e_done = (k == 4);
      e_busy = (k <= 4);
      check_output($sformatf("wrap_k%0d", k),
                   {13'h0, mem_address, dma_rvalid, dma_rdata, dma_done, dma_busy},
                   {13'h0, e_addr, e_rv, e_rd, e_done, e_busy});
    end

    // Zero-length burst: done one cycle later without ever going busy.
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h8000, 16'd0);
    idle_cycle();
    check_output("len0_done", {21'h0, mem_address, dma_rvalid, dma_done, dma_busy},
                 {21'h0, 16'h0000, 1'b0, 1'b1, 1'b0});
    idle_cycle();
    check_output("len0_after", {21'h0, mem_address, dma_rvalid, dma_done, dma_busy},
                 {21'h0, 16'h0000, 1'b0, 1'b0, 1'b0});

    // A second start while busy must not disturb the running burst.
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h8000, 16'd4);
    for (int k = 1; k <= 6; k++) begin
      if (k == 2) apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h1234, 16'd1);
      else        idle_cycle();
      e_addr = (k <= 4) ? 16'h8000 + 16'(k - 1) : 16'h0000;
      e_done = (k == 5);
      e_busy = (k <= 5);
      check_output($sformatf("busy_start_k%0d", k),
                   {22'h0, mem_address, dma_done, dma_busy},
                   {22'h0, e_addr, e_done, e_busy});
    end

    // Reset in the middle of a burst aborts it with no done pulse.
    apply_stimulus(16'h0000, 1'b0, 1'b0, 8'h00, 1'b1, 16'h8000, 16'd4);
    idle_cycle();
    idle_cycle();
    locked = 1'b0;
    #1;
    check_output("abort_async",
                 {3'b0, mem_address, mem_w, cpu_wait, cpu_data, dma_busy, dma_rvalid, dma_rdata, dma_done},
                 40'h0);
    @(negedge clock);
    check_output("abort_held",
                 {3'b0, mem_address, mem_w, cpu_wait, cpu_data, dma_busy, dma_rvalid, dma_rdata, dma_done},
                 40'h0);
    locked = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      idle_cycle();
      check_output($sformatf("abort_after_k%0d", k),
                   {37'h0, dma_done, dma_busy, dma_rvalid}, 40'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
